game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Central game controller. Owns the INITIAL/RUN/LOSE state and, once per game tick, runs
//  bird physics -> pipe scroll -> collision check strictly in that order, one step at a time.
//  Each step is a 1-cycle pulse, completed by a done pulse. Also keeps the BCD score shown on
//  the SSDs. Sits between the debouncers and flight_physics / X_RAM_NOREAD / obstacle_logic.
// PARAMETERS
//  STEP_TIMEOUT  255  max Clk cycles to wait for any *_Done before Timeout_Err (8-bit counter)
//  SCORE_MAX     99   score saturation value (two BCD digits)
// PORTS
//  Clk          in   1  system clock (sys_clk)
//  Reset        in   1  asynchronous, active-low reset
//  Start        in   1  debounced single-cycle pulse (BtnL)
//  Ack          in   1  debounced single-cycle pulse (BtnD)
//  Jump_Pulse   in   1  debounced single-cycle pulse (BtnC)
//  Frame_Tick   in   1  1-cycle game-tick request (one per VGA frame)
//  Phys_Done    in   1  flight_physics finished its step
//  Pipe_Done    in   1  pipe scroll finished; Pipe_Passed is valid in the same cycle
//  Pipe_Passed  in   1  bird cleared a pipe during this scroll
//  Coll_Done    in   1  collision check finished; Collide is valid in the same cycle
//  Collide      in   1  bird hit a pipe or the ground
//  Phys_Step    out  1  1-cycle pulse: run one physics step
//  Jump_Req     out  1  valid with Phys_Step: apply a jump impulse in this step
//  Pipe_Step    out  1  1-cycle pulse: scroll pipes by one step
//  Coll_Step    out  1  1-cycle pulse: run the collision check
//  Q_Initial    out  1  one-hot state flag
//  Q_Run        out  1  one-hot state flag
//  Q_Lose       out  1  one-hot state flag
//  Score_Tens   out  4  BCD tens digit
//  Score_Ones   out  4  BCD ones digit
//  Overrun      out  1  sticky: a tick was dropped
//  Timeout_Err  out  1  sticky: a step timed out
// BEHAVIOUR
//  - Reset low (async): state INIT; all pulses, Jump_Req, score, pending, Overrun and
//    Timeout_Err = 0; Q_Initial = 1.
//  - States: INIT, IDLE_RUN, PHYS, PIPE, CHECK, LOSE. Q_Run = 1 in IDLE_RUN/PHYS/PIPE/CHECK.
//  - INIT: Start -> IDLE_RUN; score and both sticky flags clear. All other inputs ignored.
//  - IDLE_RUN: Frame_Tick or pending -> PHYS; clear pending.
//  - Step pulses are registered and fire on the cycle the step state is entered, exactly once.
//    So Phys_Step is high 1 cycle after the Frame_Tick is sampled.
//  - PHYS: Phys_Done -> PIPE. PIPE: Pipe_Done -> CHECK. CHECK: Coll_Done -> Collide ? LOSE
//    : IDLE_RUN.
//  - A done pulse that arrives in the same cycle as its step pulse counts as completion.
//    A done for a step that is not active is ignored.
//  - Jump latch: Jump_Pulse in any Q_Run state sets jump_pend. On Phys_Step, Jump_Req = jump_pend
//    and jump_pend clears. A Jump_Pulse in that same cycle re-sets jump_pend for the next tick.
//  - Tick buffering: Frame_Tick in PHYS/PIPE/CHECK sets pending (depth 1). A tick arriving while
//    pending is already set sets Overrun. In the CHECK->LOSE transition, pending clears.
//  - Score updates at Pipe_Done with Pipe_Passed = 1. If Ones = 9, Ones -> 0 and Tens + 1;
//    otherwise Ones + 1. It holds at 9/9 (SCORE_MAX).
//  - Timeout: an 8-bit counter clears on entry to PHYS/PIPE/CHECK and increments each cycle
//    with no done. Reaching STEP_TIMEOUT sets Timeout_Err and forces LOSE.
//  - LOSE: score frozen; ticks, jumps and dones ignored. Ack -> INIT (score kept until Start).
//    Start in LOSE is ignored.
//  - Reset mid-step: immediate INIT; any step pulse in flight is dropped. Downstream blocks
//    share the same reset.
// STRUCTURE
//  - Shared package/header: state encodings (3-bit), SCORE_MAX, STEP_TIMEOUT default.
//  - One sub-module: bcd_score_counter (clr, inc, sat -> tens/ones). FSM, latches and timeout
//    counter stay in this module.
// TESTING
//  1. Reset low, Start, Frame_Tick; each done 2 cycles after its step, Collide = 0
//     -> Phys_Step, Pipe_Step, Coll_Step each pulse once, in order; back in IDLE_RUN.
//  2. Jump_Pulse in IDLE_RUN, then a tick -> Jump_Req = 1 with Phys_Step.
//     Next tick with no jump -> Jump_Req = 0.
//  3. Pipe_Passed = 1 on 12 consecutive ticks -> Tens = 1, Ones = 2.
//     Preload 98, then 3 more passes -> holds at 9/9.
//  4. Two Frame_Ticks during PIPE -> one extra sequence runs, Overrun = 1.
//     A single tick during PIPE -> Overrun stays 0.
//  5. Coll_Done with Collide = 1 -> Q_Lose = 1; ticks produce no pulses.
//     Ack -> Q_Initial; then Start -> score 0/0.
//  6. Phys_Done withheld 255 cycles -> Timeout_Err = 1, Q_Lose = 1.
//     Reset asserted in PIPE -> all outputs at reset values on the same edge.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared types and defaults for the game sequencer.
// State encoding, step timeout and score ceiling.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE_RUN = 3'd1,
    S_PHYS     = 3'd2,
    S_PIPE     = 3'd3,
    S_CHECK    = 3'd4,
    S_LOSE     = 3'd5
  } state_e;

  localparam int STEP_TIMEOUT_DEF = 255;
  localparam int SCORE_MAX_DEF    = 99;

  function automatic logic is_step(state_e s);
    return (s == S_PHYS) || (s == S_PIPE) ||
           (s == S_CHECK);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake bundle between the sequencer, the
// debouncers and the per-tick step engines.
interface game_sequencer_if;

  logic       Start;
  logic       Ack;
  logic       Jump_Pulse;
  logic       Frame_Tick;
  logic       Phys_Done;
  logic       Pipe_Done;
  logic       Pipe_Passed;
  logic       Coll_Done;
  logic       Collide;
  logic       Phys_Step;
  logic       Jump_Req;
  logic       Pipe_Step;
  logic       Coll_Step;
  logic       Q_Initial;
  logic       Q_Run;
  logic       Q_Lose;
  logic [3:0] Score_Tens;
  logic [3:0] Score_Ones;
  logic       Overrun;
  logic       Timeout_Err;

  modport master (
    output Start, Ack, Jump_Pulse, Frame_Tick,
    output Phys_Done, Pipe_Done, Pipe_Passed,
    output Coll_Done, Collide,
    input  Phys_Step, Jump_Req, Pipe_Step,
    input  Coll_Step, Q_Initial, Q_Run, Q_Lose,
    input  Score_Tens, Score_Ones,
    input  Overrun, Timeout_Err
  );

  modport slave (
    input  Start, Ack, Jump_Pulse, Frame_Tick,
    input  Phys_Done, Pipe_Done, Pipe_Passed,
    input  Coll_Done, Collide,
    output Phys_Step, Jump_Req, Pipe_Step,
    output Coll_Step, Q_Initial, Q_Run, Q_Lose,
    output Score_Tens, Score_Ones,
    output Overrun, Timeout_Err
  );

endinterface

// File: rtl/game_sequencer_bcd_score_counter.sv
// Two-digit BCD score counter that holds at
// its ceiling instead of wrapping.
module bcd_score_counter #(
  parameter int SAT = 99
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic sat;

  assign sat = (tens == 4'(SAT / 10)) &&
               (ones == 4'(SAT % 10));

  // BCD increment with carry into tens, frozen at ceiling
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !sat) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: INIT/RUN/LOSE plus the per-tick
// physics -> pipe -> collision step chain.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int STEP_TIMEOUT = STEP_TIMEOUT_DEF,
  parameter int SCORE_MAX    = SCORE_MAX_DEF
) (
  input logic             Clk,
  input logic             Reset,
  game_sequencer_if.slave bus
);

  state_e     state;
  state_e     state_n;
  logic       pending;
  logic       jump_pend;
  logic       phys_q;
  logic       pipe_q;
  logic       coll_q;
  logic       ov_q;
  logic       to_q;
  logic [7:0] tmo_cnt;
  logic       in_step;
  logic       in_run;
  logic       done;
  logic       timeout;
  logic       game_start;
  logic       score_inc;

  assign in_step    = is_step(state);
  assign in_run     = in_step || (state == S_IDLE_RUN);
  assign game_start = (state == S_INIT) && bus.Start;
  assign score_inc  = (state == S_PIPE) &&
                      bus.Pipe_Done && bus.Pipe_Passed;
  assign timeout    = in_step && !done &&
                      (tmo_cnt == 8'(STEP_TIMEOUT - 1));

  // Completion of whichever step is currently active
  always_comb begin
    done = 1'b0;
    unique case (1'b1)
      state == S_PHYS:  done = bus.Phys_Done;
      state == S_PIPE:  done = bus.Pipe_Done;
      state == S_CHECK: done = bus.Coll_Done;
      default:          done = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT:
        if (bus.Start) state_n = S_IDLE_RUN;
      S_IDLE_RUN:
        if (bus.Frame_Tick || pending)
          state_n = S_PHYS;
      S_PHYS:
        if (bus.Phys_Done)  state_n = S_PIPE;
        else if (timeout)   state_n = S_LOSE;
      S_PIPE:
        if (bus.Pipe_Done)  state_n = S_CHECK;
        else if (timeout)   state_n = S_LOSE;
      S_CHECK:
        if (bus.Coll_Done)
          state_n = bus.Collide ? S_LOSE
                                : S_IDLE_RUN;
        else if (timeout)   state_n = S_LOSE;
      S_LOSE:
        if (bus.Ack) state_n = S_INIT;
      default: state_n = S_INIT;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= state_n;
  end

  // Step pulses fire once, on entry to each step
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      phys_q <= 1'b0;
      pipe_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      phys_q <= (state == S_IDLE_RUN) &&
                (state_n == S_PHYS);
      pipe_q <= (state == S_PHYS) &&
                (state_n == S_PIPE);
      coll_q <= (state == S_PIPE) &&
                (state_n == S_CHECK);
    end
  end

  // One-deep tick buffer and sticky overrun flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pending <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (!in_run || state_n == S_LOSE)
        pending <= 1'b0;
      else if (state == S_IDLE_RUN)
        pending <= 1'b0;
      else if (bus.Frame_Tick)
        pending <= 1'b1;
      if (game_start)
        ov_q <= 1'b0;
      else if (in_step && bus.Frame_Tick && pending)
        ov_q <= 1'b1;
    end
  end

  // Jump latch, consumed by the physics step pulse
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              jump_pend <= 1'b0;
    else if (!in_run)        jump_pend <= 1'b0;
    else if (phys_q)         jump_pend <= bus.Jump_Pulse;
    else if (bus.Jump_Pulse) jump_pend <= 1'b1;
  end

  // Per-step watchdog and sticky timeout flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      if (state_n != state)
        tmo_cnt <= 8'd0;
      else if (in_step && !done)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (game_start)   to_q <= 1'b0;
      else if (timeout) to_q <= 1'b1;
    end
  end

  bcd_score_counter #(
    .SAT (SCORE_MAX)
  ) u_score (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (game_start),
    .inc   (score_inc),
    .tens  (bus.Score_Tens),
    .ones  (bus.Score_Ones)
  );

  assign bus.Phys_Step   = phys_q;
  assign bus.Jump_Req    = phys_q && jump_pend;
  assign bus.Pipe_Step   = pipe_q;
  assign bus.Coll_Step   = coll_q;
  assign bus.Q_Initial   = (state == S_INIT);
  assign bus.Q_Run       = in_run;
  assign bus.Q_Lose      = (state == S_LOSE);
  assign bus.Overrun     = ov_q;
  assign bus.Timeout_Err = to_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: game-level
// model compared every cycle plus directed checks.
module tb_game_sequencer;

  logic board_clk;
  logic Reset;

  game_sequencer_if bus ();

  game_sequencer dut (
    .Clk   (board_clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  int checks;
  int failures;

  // game-level model: 0 init, 1 running, 2 lost
  int m_phase;
  int m_score;
  bit m_ov;
  bit m_to;
  bit m_pend;

  int n_phys, n_pipe, n_coll;
  int s_phys, s_pipe, s_coll;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge board_clk);
    #1;
  endtask

  function automatic logic step_sig(input int w);
    case (w)
      0:       return bus.Phys_Step;
      1:       return bus.Pipe_Step;
      default: return bus.Coll_Step;
    endcase
  endfunction

  task automatic wait_step(input int w,
                           output int lat);
    bit hit;
    hit = 0;
    lat = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (step_sig(w)) hit = 1;
      else begin
        cyc();
        lat++;
      end
    end
    chk("step_seen", 8'(hit), 8'd1);
  endtask

  task automatic snap();
    s_phys = n_phys;
    s_pipe = n_pipe;
    s_coll = n_coll;
  endtask

  task automatic chk_delta(input string nm,
                           input int d);
    chk({nm, "_phys_cnt"}, 8'(n_phys - s_phys), 8'(d));
    chk({nm, "_pipe_cnt"}, 8'(n_pipe - s_pipe), 8'(d));
    chk({nm, "_coll_cnt"}, 8'(n_coll - s_coll), 8'(d));
  endtask

  task automatic press_start();
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1;
      m_score = 0;
      m_ov    = 0;
      m_to    = 0;
      m_pend  = 0;
    end
  endtask

  task automatic press_ack();
    bus.Ack = 1'b1;
    cyc();
    bus.Ack = 1'b0;
    if (m_phase == 2) m_phase = 0;
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_phys"},  8'(bus.Phys_Step),   8'd0);
    chk({nm, "_jump"},  8'(bus.Jump_Req),    8'd0);
    chk({nm, "_pipe"},  8'(bus.Pipe_Step),   8'd0);
    chk({nm, "_coll"},  8'(bus.Coll_Step),   8'd0);
    chk({nm, "_qinit"}, 8'(bus.Q_Initial),   8'd1);
    chk({nm, "_qrun"},  8'(bus.Q_Run),       8'd0);
    chk({nm, "_qlose"}, 8'(bus.Q_Lose),      8'd0);
    chk({nm, "_tens"},  8'(bus.Score_Tens),  8'd0);
    chk({nm, "_ones"},  8'(bus.Score_Ones),  8'd0);
    chk({nm, "_ovr"},   8'(bus.Overrun),     8'd0);
    chk({nm, "_tmo"},   8'(bus.Timeout_Err), 8'd0);
  endtask

  // One full game tick; dones come 2 cycles after
  // each step. tk=0 means a buffered tick starts it.
  task automatic run_seq(input bit tk,
                         input bit passed,
                         input bit coll,
                         input bit jexp,
                         input bit jas,
                         input int npipe);
    int lat;
    if (tk) begin
      bus.Frame_Tick = 1'b1;
      cyc();
      bus.Frame_Tick = 1'b0;
    end
    m_pend = 0;
    wait_step(0, lat);
    chk("phys_latency", 8'(lat), tk ? 8'd0 : 8'd1);
    chk("jump_req", 8'(bus.Jump_Req), 8'(jexp));
    bus.Jump_Pulse = jas;
    cyc();
    bus.Jump_Pulse = 1'b0;
    cyc();
    bus.Phys_Done = 1'b1;
    cyc();
    bus.Phys_Done = 1'b0;
    wait_step(1, lat);
    chk("pipe_latency", 8'(lat), 8'd0);
    for (int k = 0; k < 2; k++) begin
      if (k < npipe) begin
        bus.Frame_Tick = 1'b1;
        cyc();
        bus.Frame_Tick = 1'b0;
        if (m_pend) m_ov = 1;
        else        m_pend = 1;
      end else begin
        cyc();
      end
    end
    bus.Pipe_Done   = 1'b1;
    bus.Pipe_Passed = passed;
    cyc();
    bus.Pipe_Done   = 1'b0;
    bus.Pipe_Passed = 1'b0;
    if (passed && m_score < 99) m_score++;
    wait_step(2, lat);
    chk("coll_latency", 8'(lat), 8'd0);
    cyc();
    cyc();
    bus.Coll_Done = 1'b1;
    bus.Collide   = coll;
    cyc();
    bus.Coll_Done = 1'b0;
    bus.Collide   = 1'b0;
    if (coll) begin
      m_phase = 2;
      m_pend  = 0;
    end
  endtask

  logic [2:0] prev_steps;

  initial begin
    int lat;
    logic [2:0] cur;
    checks   = 0;
    failures = 0;
    m_phase  = 0;
    m_score  = 0;
    m_ov     = 0;
    m_to     = 0;
    m_pend   = 0;
    n_phys   = 0;
    n_pipe   = 0;
    n_coll   = 0;
    prev_steps = 3'b000;
    bus.Start       = 1'b0;
    bus.Ack         = 1'b0;
    bus.Jump_Pulse  = 1'b0;
    bus.Frame_Tick  = 1'b0;
    bus.Phys_Done   = 1'b0;
    bus.Pipe_Done   = 1'b0;
    bus.Pipe_Passed = 1'b0;
    bus.Coll_Done   = 1'b0;
    bus.Collide     = 1'b0;
    Reset           = 1'b0;

    fork
      forever begin
        @(negedge board_clk);
        if (Reset) begin
          cur = {bus.Coll_Step, bus.Pipe_Step,
                 bus.Phys_Step};
          chk("q_initial", 8'(bus.Q_Initial),
              8'(m_phase == 0));
          chk("q_run", 8'(bus.Q_Run),
              8'(m_phase == 1));
          chk("q_lose", 8'(bus.Q_Lose),
              8'(m_phase == 2));
          chk("score_tens", 8'(bus.Score_Tens),
              8'(m_score / 10));
          chk("score_ones", 8'(bus.Score_Ones),
              8'(m_score % 10));
          chk("overrun", 8'(bus.Overrun), 8'(m_ov));
          chk("timeout_err", 8'(bus.Timeout_Err),
              8'(m_to));
          if (m_phase != 1)
            chk("no_step_idle", 8'(cur), 8'd0);
          else
            chk("step_onehot",
                8'($countones(cur) <= 1), 8'd1);
          chk("step_single", 8'(cur & prev_steps),
              8'd0);
          n_phys += int'(cur[0]);
          n_pipe += int'(cur[1]);
          n_coll += int'(cur[2]);
          prev_steps = cur;
        end else begin
          prev_steps = 3'b000;
        end
      end
    join_none

    repeat (3) @(posedge board_clk);
    #1;
    reset_checks("por");
    Reset = 1'b1;
    cyc();
    press_start();
    chk("start_q_run", 8'(bus.Q_Run), 8'd1);

    // plain tick, no collision
    snap();
    run_seq(1, 0, 0, 0, 0, 0);
    chk_delta("t1", 1);
    chk("t1_back_run", 8'(bus.Q_Run), 8'd1);

    // jump latching
    bus.Jump_Pulse = 1'b1;
    cyc();
    bus.Jump_Pulse = 1'b0;
    run_seq(1, 0, 0, 1, 1, 0);
    run_seq(1, 0, 0, 1, 0, 0);
    run_seq(1, 0, 0, 0, 0, 0);

    // scoring and saturation
    repeat (12) run_seq(1, 1, 0, 0, 0, 0);
    chk("t3_tens12", 8'(bus.Score_Tens), 8'd1);
    chk("t3_ones12", 8'(bus.Score_Ones), 8'd2);
    repeat (86) run_seq(1, 1, 0, 0, 0, 0);
    chk("t3_tens98", 8'(bus.Score_Tens), 8'd9);
    chk("t3_ones98", 8'(bus.Score_Ones), 8'd8);
    repeat (3) run_seq(1, 1, 0, 0, 0, 0);
    chk("t3_tens_sat", 8'(bus.Score_Tens), 8'd9);
    chk("t3_ones_sat", 8'(bus.Score_Ones), 8'd9);

    // tick buffering
    snap();
    run_seq(1, 0, 0, 0, 0, 1);
    run_seq(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk_delta("t4_single", 2);
    chk("t4_single_ovr", 8'(bus.Overrun), 8'd0);
    snap();
    run_seq(1, 0, 0, 0, 0, 2);
    run_seq(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk_delta("t4_double", 2);
    chk("t4_double_ovr", 8'(bus.Overrun), 8'd1);

    // collision and lose handling
    run_seq(1, 0, 1, 0, 0, 0);
    chk("t5_lose", 8'(bus.Q_Lose), 8'd1);
    snap();
    repeat (3) begin
      bus.Frame_Tick = 1'b1;
      bus.Jump_Pulse = 1'b1;
      bus.Phys_Done  = 1'b1;
      bus.Start      = 1'b1;
      cyc();
      bus.Frame_Tick = 1'b0;
      bus.Jump_Pulse = 1'b0;
      bus.Phys_Done  = 1'b0;
      bus.Start      = 1'b0;
      cyc();
    end
    chk_delta("t5_lose", 0);
    chk("t5_still_lose", 8'(bus.Q_Lose), 8'd1);
    press_ack();
    chk("t5_ack_init", 8'(bus.Q_Initial), 8'd1);
    chk("t5_kept_tens", 8'(bus.Score_Tens), 8'd9);
    chk("t5_kept_ones", 8'(bus.Score_Ones), 8'd9);
    press_start();
    chk("t5_clr_tens", 8'(bus.Score_Tens), 8'd0);
    chk("t5_clr_ones", 8'(bus.Score_Ones), 8'd0);
    chk("t5_clr_ovr", 8'(bus.Overrun), 8'd0);

    // step watchdog
    bus.Frame_Tick = 1'b1;
    cyc();
    bus.Frame_Tick = 1'b0;
    wait_step(0, lat);
    chk("t6_jump", 8'(bus.Jump_Req), 8'd0);
    repeat (254) cyc();
    chk("t6_not_yet", 8'(bus.Q_Run), 8'd1);
    cyc();
    m_phase = 2;
    m_to    = 1;
    chk("t6_tmo", 8'(bus.Timeout_Err), 8'd1);
    chk("t6_lose", 8'(bus.Q_Lose), 8'd1);

    // asynchronous reset while pipes scroll
    press_ack();
    press_start();
    bus.Frame_Tick = 1'b1;
    cyc();
    bus.Frame_Tick = 1'b0;
    wait_step(0, lat);
    cyc();
    bus.Phys_Done = 1'b1;
    cyc();
    bus.Phys_Done = 1'b0;
    wait_step(1, lat);
    #2;
    Reset   = 1'b0;
    m_phase = 0;
    m_score = 0;
    m_ov    = 0;
    m_to    = 0;
    m_pend  = 0;
    #1;
    reset_checks("mid_rst");
    cyc();
    Reset = 1'b1;
    repeat (3) cyc();
    chk("post_rst_init", 8'(bus.Q_Initial), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
